vixen_mul_unit: RTL and testbench

VIXEN_MUL_UNIT -- requirements
Module: vixen_mul_unit

---
 rtl/vixen_mul_unit.sv | 158 +++++++++++++++
 tb/tb_vixen_mul_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vixen_mul_unit.sv
// Three-stage pipelined 32x32 integer multiplier with writeback handshake,
// per-thread flush and a sticky error flag for issues attempted while busy.
module vixen_mul_unit #(
    parameter int unsigned ROB_ID_W    = 6,
    parameter int unsigned NUM_THREADS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mul_issue_valid,
    input  logic [63:0]            mul_issue_uop,
    input  logic [ROB_ID_W-1:0]    mul_issue_rob_id,
    input  logic [1:0]             mul_issue_thread_id,
    input  logic [31:0]            mul_src_a,
    input  logic [31:0]            mul_src_b,
    input  logic                   flush_valid,
    input  logic [NUM_THREADS-1:0] flush_thread_mask,
    input  logic                   mul_wb_ready,
    output logic                   mul_wb_valid,
    output logic [31:0]            mul_wb_result,
    output logic [ROB_ID_W-1:0]    mul_wb_rob_id,
    output logic [1:0]             mul_wb_thread_id,
    output logic                   mul_wb_exc,
    output logic                   eu_mul_busy,
    output logic                   mul_issue_err
);

    localparam int unsigned TID_W  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPND_W = DATA_W + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned MASK_W = 1 << TID_W;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b011;

    typedef struct packed {
        logic                valid;
        logic [2:0]          op;
        logic [ROB_ID_W-1:0] rob_id;
        logic [TID_W-1:0]    tid;
    } ctrl_t;

    ctrl_t               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [OPND_W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [PROD_W-1:0]   s2_prod_q, s2_prod_d;
    logic [DATA_W-1:0]   s3_result_q, s3_result_d;
    logic                s3_exc_q, s3_exc_d;
    logic                issue_err_q, issue_err_d;

    logic [MASK_W-1:0]   kill_mask;
    logic                stall;
    logic                kill_issue;
    logic                accept;
    logic [2:0]          issue_op;
    logic                a_signed;
    logic                b_signed;
    logic [PROD_W-1:0]   a_ext;
    logic [PROD_W-1:0]   b_ext;
    logic                unused_uop;

    assign unused_uop = ^mul_issue_uop[63:3];
    assign issue_op   = mul_issue_uop[2:0];

    // Flush mask widened to the full thread-id space; ids beyond NUM_THREADS never match
    assign kill_mask  = flush_valid ? MASK_W'(flush_thread_mask) : '0;
    assign stall      = s3_q.valid & ~mul_wb_ready;
    assign kill_issue = kill_mask[mul_issue_thread_id];
    assign accept     = mul_issue_valid & ~stall & ~kill_issue;

    // Operands carry one extra bit so a single signed multiply covers all variants
    assign a_signed = (issue_op == OP_MULH) | (issue_op == OP_MULHSU);
    assign b_signed = (issue_op == OP_MULH);
    assign a_ext    = {{(PROD_W-OPND_W){s1_a_q[OPND_W-1]}}, s1_a_q};
    assign b_ext    = {{(PROD_W-OPND_W){s1_b_q[OPND_W-1]}}, s1_b_q};

    always_comb begin
        s1_d        = s1_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_d        = s2_q;
        s2_prod_d   = s2_prod_q;
        s3_d        = s3_q;
        s3_result_d = s3_result_q;
        s3_exc_d    = s3_exc_q;

        // Flush invalidates matching stages even while the pipe is held
        s1_d.valid = s1_q.valid & ~kill_mask[s1_q.tid];
        s2_d.valid = s2_q.valid & ~kill_mask[s2_q.tid];
        s3_d.valid = s3_q.valid & ~kill_mask[s3_q.tid];

        if (!stall) begin
            s3_d        = s2_q;
            s3_d.valid  = s2_q.valid & ~kill_mask[s2_q.tid];
            s3_exc_d    = s2_q.op[2];
            if (s2_q.op[2]) begin
                s3_result_d = '0;
            end else if (s2_q.op == OP_MUL) begin
                s3_result_d = s2_prod_q[DATA_W-1:0];
            end else begin
                s3_result_d = s2_prod_q[PROD_W-1:DATA_W];
            end

            s2_d        = s1_q;
            s2_d.valid  = s1_q.valid & ~kill_mask[s1_q.tid];
            s2_prod_d   = a_ext * b_ext;

            s1_d.valid  = accept;
            s1_d.op     = issue_op;
            s1_d.rob_id = mul_issue_rob_id;
            s1_d.tid    = mul_issue_thread_id;
            s1_a_d      = {a_signed & mul_src_a[DATA_W-1], mul_src_a};
            s1_b_d      = {b_signed & mul_src_b[DATA_W-1], mul_src_b};
        end

        // Writeback payload reads as zero whenever no result is presented
        if (!s3_d.valid) begin
            s3_d        = '0;
            s3_result_d = '0;
            s3_exc_d    = 1'b0;
        end

        issue_err_d = issue_err_q | (mul_issue_valid & stall & ~kill_issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_q        <= '0;
            s2_prod_q   <= '0;
            s3_q        <= '0;
            s3_result_q <= '0;
            s3_exc_q    <= 1'b0;
            issue_err_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_q        <= s2_d;
            s2_prod_q   <= s2_prod_d;
            s3_q        <= s3_d;
            s3_result_q <= s3_result_d;
            s3_exc_q    <= s3_exc_d;
            issue_err_q <= issue_err_d;
        end
    end

    assign mul_wb_valid     = s3_q.valid;
    assign mul_wb_result    = s3_result_q;
    assign mul_wb_rob_id    = s3_q.rob_id;
    assign mul_wb_thread_id = s3_q.tid;
    assign mul_wb_exc       = s3_exc_q;
    assign eu_mul_busy      = stall;
    assign mul_issue_err    = issue_err_q;

endmodule

// File: tb/tb_vixen_mul_unit.sv
// Scoreboard bench for vixen_mul_unit: directed scenarios plus random traffic
// checked against an arithmetic reference model of the multiplier pipeline.
module tb_vixen_mul_unit;

    localparam int unsigned NT = 2;

    logic          clk;
    logic          rst_n;
    logic          mul_issue_valid;
    logic [63:0]   mul_issue_uop;
    logic [5:0]    mul_issue_rob_id;
    logic [1:0]    mul_issue_thread_id;
    logic [31:0]   mul_src_a;
    logic [31:0]   mul_src_b;
    logic          flush_valid;
    logic [NT-1:0] flush_thread_mask;
    logic          mul_wb_ready;
    logic          mul_wb_valid;
    logic [31:0]   mul_wb_result;
    logic [5:0]    mul_wb_rob_id;
    logic [1:0]    mul_wb_thread_id;
    logic          mul_wb_exc;
    logic          eu_mul_busy;
    logic          mul_issue_err;

    vixen_mul_unit #(.ROB_ID_W(6), .NUM_THREADS(NT)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mul_issue_valid     (mul_issue_valid),
        .mul_issue_uop       (mul_issue_uop),
        .mul_issue_rob_id    (mul_issue_rob_id),
        .mul_issue_thread_id (mul_issue_thread_id),
        .mul_src_a           (mul_src_a),
        .mul_src_b           (mul_src_b),
        .flush_valid         (flush_valid),
        .flush_thread_mask   (flush_thread_mask),
        .mul_wb_ready        (mul_wb_ready),
        .mul_wb_valid        (mul_wb_valid),
        .mul_wb_result       (mul_wb_result),
        .mul_wb_rob_id       (mul_wb_rob_id),
        .mul_wb_thread_id    (mul_wb_thread_id),
        .mul_wb_exc          (mul_wb_exc),
        .eu_mul_busy         (eu_mul_busy),
        .mul_issue_err       (mul_issue_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [5:0]  rob;
        logic [1:0]  tid;
        logic        exc;
        int          pos;
    } exp_t;

    exp_t exp_q[$];
    logic m_err;
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference arithmetic on full-width integers
    function automatic exp_t predict(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [5:0] rob,
                                     input logic [1:0] tid);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        e.rob = rob;
        e.tid = tid;
        e.exc = 1'b0;
        e.pos = 0;
        case (op)
            3'd0: begin u = {32'd0, a} * {32'd0, b}; e.result = u[31:0]; end
            3'd1: begin p = longint'(int'(a)) * longint'(int'(b)); u = p; e.result = u[63:32]; end
            3'd2: begin u = {32'd0, a} * {32'd0, b}; e.result = u[63:32]; end
            3'd3: begin p = longint'(int'(a)) * longint'({32'd0, b}); u = p; e.result = u[63:32]; end
            default: begin e.result = 32'd0; e.exc = 1'b1; end
        endcase
        return e;
    endfunction

    // Abstract pipeline: each op occupies a slot 1..3, whole pipe freezes on a stall
    task automatic model_step();
        logic       stall;
        logic [3:0] m4;
        if (!rst_n) begin
            exp_q.delete();
            m_err = 1'b0;
            return;
        end
        m4    = flush_valid ? 4'(flush_thread_mask) : 4'b0;
        stall = (exp_q.size() != 0) && (exp_q[0].pos == 3) && !mul_wb_ready;
        if (mul_issue_valid && !m4[mul_issue_thread_id]) begin
            if (stall) m_err = 1'b1;
            else exp_q.push_back(predict(mul_issue_uop[2:0], mul_src_a, mul_src_b,
                                         mul_issue_rob_id, mul_issue_thread_id));
        end
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (m4[exp_q[i].tid]) exp_q.delete(i);
        if (!stall)
            foreach (exp_q[i]) exp_q[i].pos++;
    endtask

    task automatic cyc(input logic iv, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] rob, input logic [1:0] tid,
                       input logic fl, input logic [NT-1:0] fm, input logic rdy);
        mul_issue_valid     = iv;
        mul_issue_uop       = {32'($urandom), 29'($urandom), op};
        mul_src_a           = a;
        mul_src_b           = b;
        mul_issue_rob_id    = rob;
        mul_issue_thread_id = tid;
        flush_valid         = fl;
        flush_thread_mask   = fm;
        mul_wb_ready        = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 6'd0, 2'd0, 1'b0, '0, rdy);
    endtask

    // Monitor: compares the presented result with the scoreboard head every cycle
    always @(negedge clk) begin
        logic have;
        exp_t e;
        have = (exp_q.size() != 0) && (exp_q[0].pos == 3);
        if (have) begin
            e = exp_q[0];
            chk("wb_payload", 64'({mul_wb_valid, mul_wb_result, mul_wb_rob_id, mul_wb_thread_id, mul_wb_exc}),
                64'({1'b1, e.result, e.rob, e.tid, e.exc}));
            if (mul_wb_ready) void'(exp_q.pop_front());
        end else begin
            chk("wb_idle", 64'({mul_wb_valid, mul_wb_result, mul_wb_rob_id, mul_wb_thread_id, mul_wb_exc}),
                64'd0);
        end
        chk("busy", 64'(eu_mul_busy), 64'(have && !mul_wb_ready));
        chk("issue_err", 64'(mul_issue_err), 64'(m_err));
    end

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk_all_zero(input string name);
        chk(name, 64'({mul_wb_valid, mul_wb_result, mul_wb_rob_id, mul_wb_thread_id,
                       mul_wb_exc, eu_mul_busy, mul_issue_err}), 64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_err = 1'b0;
        rst_n = 1'b0;
        mul_issue_valid = 1'b0; mul_issue_uop = '0; mul_issue_rob_id = '0;
        mul_issue_thread_id = '0; mul_src_a = '0; mul_src_b = '0;
        flush_valid = 1'b0; flush_thread_mask = '0; mul_wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        rst_n = 1'b1;

        // Single MUL, fixed latency
        cyc(1'b1, 3'd0, 32'd7, 32'd6, 6'd5, 2'd1, 1'b0, '0, 1'b1);
        idle(4, 1'b1);

        // All-ones operands across the four opcodes back to back
        cyc(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13, 2'd0, 1'b0, '0, 1'b1);
        idle(5, 1'b1);

        // Flush thread 0 while held; thread-0 issue in the same cycle is discarded silently
        cyc(1'b1, 3'd0, 32'd3, 32'd4, 6'd1, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd0, 32'd5, 32'd6, 6'd2, 2'd1, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd2, 32'd8, 32'd9, 6'd3, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd0, 32'd1, 32'd1, 6'd9, 2'd0, 1'b1, 2'b01, 1'b0);
        idle(2, 1'b0);
        idle(5, 1'b1);

        // Illegal opcode
        cyc(1'b1, 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 6'd20, 2'd1, 1'b0, '0, 1'b1);
        idle(4, 1'b1);

        // Backpressure with an issue attempted during the stall
        cyc(1'b1, 3'd0, 32'd100, 32'd3, 6'd30, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd1, 32'hFFFF_FF00, 32'd77, 6'd31, 2'd1, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd32, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd0, 32'd2, 32'd2, 6'd33, 2'd1, 1'b0, '0, 1'b0);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Asynchronous reset with three ops in flight
        cyc(1'b1, 3'd0, 32'd11, 32'd12, 6'd40, 2'd0, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd2, 32'd13, 32'd14, 6'd41, 2'd1, 1'b0, '0, 1'b1);
        cyc(1'b1, 3'd1, 32'd15, 32'd16, 6'd42, 2'd0, 1'b0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        m_err = 1'b0;
        idle(2, 1'b1);
        rst_n = 1'b1;
        cyc(1'b1, 3'd0, 32'd9, 32'd9, 6'd43, 2'd1, 1'b0, '0, 1'b1);
        idle(4, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(),
                6'($urandom),
                ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0), 2'($urandom_range(1, 3)),
                ($urandom_range(0, 3) != 0));
        end
        idle(8, 1'b1);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
